// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// A private shadow of ID/EX, EX/MEM and MEM/WB destination info drives the
// EX operand forwarding selects and the stall/bubble/flush/freeze controls.

// Forwarding select for one EX operand. EX/MEM takes precedence over MEM/WB.
module hfc_fwd_sel #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  use_src,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  mem_valid,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);
  logic mem_hit, wb_hit;

  // Register 0 is hardwired, so a write to it never produces a forward.
  assign mem_hit = mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_valid  && wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src);

  // Pick the youngest producer; an empty EX slot or unused operand reads the register file.
  always_comb begin
    sel = 2'b00;
    if (ex_valid && use_src) begin
      if (mem_hit)     sel = 2'b10;
      else if (wb_hit) sel = 2'b01;
    end
  end
endmodule

module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_stall_i,
  output logic [1:0]            fwdA_o,
  output logic [1:0]            fwdB_o,
  output logic                  pc_hold_o,
  output logic                  ifid_hold_o,
  output logic                  idex_bubble_o,
  output logic                  ifid_flush_o,
  output logic                  pipe_freeze_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);
  localparam int NUM_OPS = 2;

  // EX needs the full source view; later stages only matter as producers.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } ex_stage_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } dst_stage_t;

  ex_stage_t  s_ex;
  dst_stage_t s_mem, s_wb;
  logic       lu;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] op_src;
  logic [NUM_OPS-1:0]                 op_use;
  logic [NUM_OPS-1:0][1:0]            op_sel;

  // Load in EX whose result the ID instruction needs: one bubble is unavoidable.
  assign lu = s_ex.valid && s_ex.memread && s_ex.regwrite && (s_ex.rd != '0) &&
              id_valid_i &&
              ((id_use_rs_i && (id_rs_i == s_ex.rd)) ||
               (id_use_rt_i && (id_rt_i == s_ex.rd)));

  // Shadow pipeline and saturating stall counter; memory stall freezes everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_ex        <= '0;
      s_mem       <= '0;
      s_wb        <= '0;
      stall_cnt_o <= '0;
    end else if (!mem_stall_i) begin
      s_wb  <= s_mem;
      s_mem <= '{valid: s_ex.valid, rd: s_ex.rd, regwrite: s_ex.regwrite};
      s_ex  <= '{valid: id_valid_i && !lu, rs: id_rs_i, rt: id_rt_i,
                 use_rs: id_use_rs_i, use_rt: id_use_rt_i, rd: id_rd_i,
                 regwrite: id_regwrite_i, memread: id_memread_i};
      if (lu && (stall_cnt_o != '1))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  assign op_src = {s_ex.rt, s_ex.rs};
  assign op_use = {s_ex.use_rt, s_ex.use_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    hfc_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .ex_valid     (s_ex.valid),
      .use_src      (op_use[g]),
      .src          (op_src[g]),
      .mem_valid    (s_mem.valid),
      .mem_regwrite (s_mem.regwrite),
      .mem_rd       (s_mem.rd),
      .wb_valid     (s_wb.valid),
      .wb_regwrite  (s_wb.regwrite),
      .wb_rd        (s_wb.rd),
      .sel          (op_sel[g])
    );
  end

  // Control outputs: reset forces idle, then mem stall > load-use > taken branch.
  always_comb begin
    fwdA_o        = 2'b00;
    fwdB_o        = 2'b00;
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    pipe_freeze_o = 1'b0;
    if (!rst_i) begin
      fwdA_o = op_sel[0];
      fwdB_o = op_sel[1];
      if (mem_stall_i) begin
        pipe_freeze_o = 1'b1;
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
      end else if (lu) begin
        pc_hold_o     = 1'b1;
        ifid_hold_o   = 1'b1;
        idex_bubble_o = 1'b1;
      end else begin
        ifid_flush_o  = branch_taken_i;
      end
    end
  end
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Randomized + directed bench for hazard_forward_ctrl against an
// instruction-level reference model of the three shadow stages.
module tb_hazard_forward_ctrl;
  localparam int AW = 5;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          rst_i = 1'b1;
  logic          id_valid_i = 1'b0;
  logic [AW-1:0] id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
  logic          id_use_rs_i = 1'b0, id_use_rt_i = 1'b0;
  logic          id_regwrite_i = 1'b0, id_memread_i = 1'b0;
  logic          branch_taken_i = 1'b0, mem_stall_i = 1'b0;
  logic [1:0]    fwdA_o, fwdB_o;
  logic          pc_hold_o, ifid_hold_o, idex_bubble_o, ifid_flush_o, pipe_freeze_o;
  logic [CW-1:0] stall_cnt_o;

  hazard_forward_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rs_i(id_use_rs_i),
    .id_use_rt_i(id_use_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .branch_taken_i(branch_taken_i),
    .mem_stall_i(mem_stall_i), .fwdA_o(fwdA_o), .fwdB_o(fwdB_o),
    .pc_hold_o(pc_hold_o), .ifid_hold_o(ifid_hold_o), .idex_bubble_o(idex_bubble_o),
    .ifid_flush_o(ifid_flush_o), .pipe_freeze_o(pipe_freeze_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [4:0] rd;
    bit       rw, mr;
  } ins_t;

  // Model: index 0 = instruction in EX, 1 = in MEM, 2 = in WB.
  ins_t pipe [3];
  int   m_cnt;
  bit   known = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(int v, int rs, int rt, int urs, int urt, int rd, int rw, int mr);
    ins_t i;
    i.v = v[0]; i.rs = rs[4:0]; i.rt = rt[4:0]; i.urs = urs[0]; i.urt = urt[0];
    i.rd = rd[4:0]; i.rw = rw[0]; i.mr = mr[0];
    return i;
  endfunction

  function automatic bit m_lu();
    ins_t e = pipe[0];
    if (!(e.v && e.mr && e.rw && e.rd != 0 && id_valid_i)) return 0;
    return (id_use_rs_i && id_rs_i == e.rd) || (id_use_rt_i && id_rt_i == e.rd);
  endfunction

  // Search older instructions youngest-first for a producer of src.
  function automatic int m_fwd(bit [4:0] src, bit use_src);
    if (!pipe[0].v || !use_src) return 0;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == src)
        return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic check_now();
    bit lu;
    int fa, fb;
    if (!known) return;
    lu = m_lu();
    fa = rst_i ? 0 : m_fwd(pipe[0].rs, pipe[0].urs);
    fb = rst_i ? 0 : m_fwd(pipe[0].rt, pipe[0].urt);
    chk("fwdA", fwdA_o, fa);
    chk("fwdB", fwdB_o, fb);
    chk("freeze", pipe_freeze_o, !rst_i && mem_stall_i);
    chk("pc_hold", pc_hold_o, !rst_i && (mem_stall_i || lu));
    chk("ifid_hold", ifid_hold_o, !rst_i && (mem_stall_i || lu));
    chk("bubble", idex_bubble_o, !rst_i && !mem_stall_i && lu);
    chk("flush", ifid_flush_o, !rst_i && !mem_stall_i && !lu && branch_taken_i);
    chk("stall_cnt", stall_cnt_o, m_cnt);
  endtask

  task automatic step(input bit rst, input bit ms, input bit br, input ins_t i);
    bit lu;
    rst_i = rst; mem_stall_i = ms; branch_taken_i = br;
    id_valid_i = i.v; id_rs_i = i.rs; id_rt_i = i.rt; id_use_rs_i = i.urs;
    id_use_rt_i = i.urt; id_rd_i = i.rd; id_regwrite_i = i.rw; id_memread_i = i.mr;
    @(negedge clk);
    check_now();
    @(posedge clk);
    lu = m_lu();
    if (rst) begin
      foreach (pipe[k]) pipe[k].v = 0;
      m_cnt = 0;
      known = 1;
    end else if (known && !ms) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = i;
      pipe[0].v = i.v && !lu;
      if (lu && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  function automatic ins_t rnd_ins();
    return mk(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1));
  endfunction

  ins_t nop, add3, sub3, add0, sub0, add5, indep, or5, lw7, add7;

  initial begin
    nop   = mk(0, 0, 0, 0, 0, 0, 0, 0);
    add3  = mk(1, 1, 2, 1, 1, 3, 1, 0);
    sub3  = mk(1, 3, 4, 1, 1, 6, 1, 0);
    add0  = mk(1, 1, 2, 1, 1, 0, 1, 0);
    sub0  = mk(1, 0, 4, 1, 1, 6, 1, 0);
    add5  = mk(1, 1, 2, 1, 1, 5, 1, 0);
    indep = mk(1, 8, 9, 1, 1, 10, 1, 0);
    or5   = mk(1, 11, 5, 1, 1, 12, 1, 0);
    lw7   = mk(1, 1, 0, 1, 0, 7, 1, 1);
    add7  = mk(1, 7, 2, 1, 1, 9, 1, 0);

    // Reset with arbitrary inputs, then one clean cycle.
    step(1, 1, 1, rnd_ins());
    step(1, 1, 1, lw7);
    chk("rst_cnt", stall_cnt_o, 0);
    step(0, 0, 0, nop);

    // EX/MEM forward.
    step(0, 0, 0, add3); step(0, 0, 0, sub3);
    chk("ex_fwdA", fwdA_o, 2);
    step(0, 0, 0, nop);
    // Both EX/MEM and MEM/WB hold rd=3: EX/MEM wins.
    step(0, 0, 0, add3); step(0, 0, 0, add3); step(0, 0, 0, sub3);
    chk("ex_both_fwdA", fwdA_o, 2);
    // rd=0 never forwarded.
    step(0, 0, 0, add0); step(0, 0, 0, sub0);
    chk("r0_fwdA", fwdA_o, 0);

    // MEM/WB forward on operand B.
    step(0, 0, 0, add5); step(0, 0, 0, indep); step(0, 0, 0, or5);
    chk("mem_fwdB", fwdB_o, 1);
    step(0, 0, 0, nop); step(0, 0, 0, nop);

    // Load-use: one bubble, counter 0->1, then MEM/WB forward.
    step(0, 0, 0, lw7);
    chk("lu_cnt0", stall_cnt_o, 0);
    step(0, 0, 1, add7);              // LU with a taken branch: flush suppressed
    chk("lu_cnt1", stall_cnt_o, 1);
    step(0, 0, 0, add7);
    chk("lu_fwdA", fwdA_o, 1);
    step(0, 0, 0, nop);

    // Memory stall freezes a pending forward for 3 cycles.
    step(0, 0, 0, add3); step(0, 0, 0, sub3);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 1, rnd_ins());
      chk("frz_fwdA", fwdA_o, 2);
      chk("frz_cnt", stall_cnt_o, 1);
    end
    step(0, 0, 0, nop); step(0, 0, 0, nop);

    // Saturation: enough load-use stalls to pass the all-ones limit.
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, lw7); step(0, 0, 0, add7); step(0, 0, 0, add7);
    end
    chk("sat_cnt", stall_cnt_o, CNT_MAX);

    // Reset while memory is stalled and a forward is pending.
    step(0, 0, 0, add3); step(0, 0, 0, sub3);
    step(1, 1, 0, rnd_ins());
    chk("midrst_cnt", stall_cnt_o, 0);
    chk("midrst_fwdA", fwdA_o, 0);
    step(0, 0, 0, nop);

    // Random traffic.
    for (int c = 0; c < 3000; c++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
           $urandom_range(0, 1), rnd_ins());

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage pipelined CPU.
- Tracks destination-register info for the ID/EX, EX/MEM and MEM/WB stages in a private shadow pipeline.
- Drives the 2-bit select of both EX-stage operand forwarding muxes (00 = register file, 01 = MEM/WB, 10 = EX/MEM).
- Drives PC/IF-ID hold, ID/EX bubble insertion, IF/ID flush on taken branch, and a whole-pipe freeze while data memory is busy. Keeps a load-use stall counter.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
id_valid_i  in  1  ID stage holds a real instruction
id_rs_i  in  REG_ADDR_W  ID source register 1
id_rt_i  in  REG_ADDR_W  ID source register 2
id_use_rs_i  in  1  instruction reads rs
id_use_rt_i  in  1  instruction reads rt
id_rd_i  in  REG_ADDR_W  final destination register (after RegDst select)
id_regwrite_i  in  1  instruction writes register file
id_memread_i  in  1  instruction is a load
branch_taken_i  in  1  branch resolved taken in ID
mem_stall_i  in  1  data memory busy this cycle
fwdA_o  out  2  select for EX operand A mux
fwdB_o  out  2  select for EX operand B mux
pc_hold_o  out  1  PC keeps its value
ifid_hold_o  out  1  IF/ID register keeps its value
idex_bubble_o  out  1  load NOP into ID/EX
ifid_flush_o  out  1  clear IF/ID to NOP
pipe_freeze_o  out  1  all pipeline registers hold
stall_cnt_o  out  CNT_W  load-use bubble cycles since reset

Behaviour:
- Shadow stage entry fields: valid, rs, rt, use_rs, use_rt, rd, regwrite, memread.
- Three shadow stages: S_EX (mirrors ID/EX), S_MEM (EX/MEM), S_WB (MEM/WB).
- Reset (rst_i=1 at an edge): all stage valid bits = 0 and stall_cnt_o = 0. Reset has priority over every other input, including mid-stall and mid-freeze.
- After reset, all combinational outputs evaluate to 0: fwd = 00, holds/bubble/flush/freeze = 0.
- Load-use hazard LU (combinational) is 1 when all of the following hold:
  - S_EX.valid, S_EX.memread, S_EX.regwrite are 1 and S_EX.rd != 0;
  - id_valid_i = 1;
  - (id_use_rs_i and id_rs_i == S_EX.rd) or (id_use_rt_i and id_rt_i == S_EX.rd).
- Output priority is mem_stall_i > LU > branch_taken_i:
  - mem_stall_i=1: pipe_freeze_o=pc_hold_o=ifid_hold_o=1; idex_bubble_o=ifid_flush_o=0.
  - else LU=1: pc_hold_o=ifid_hold_o=idex_bubble_o=1; ifid_flush_o=0. A taken branch is ignored and is re-evaluated next cycle.
  - else: ifid_flush_o = branch_taken_i; all holds = 0.
- Shadow advance at each non-reset edge:
  - mem_stall_i=1: all stages hold and the counter holds.
  - else: S_WB <= S_MEM and S_MEM <= S_EX.
  - S_EX <= ID fields with valid = id_valid_i & ~LU. A bubble carries valid = 0.
  - On LU, stall_cnt_o increments by 1 and saturates at all-ones (no wrap).
- Forwarding for operand A (combinational from shadow state; operand B is identical using rt/use_rt):
  - 10 if S_EX.valid & S_EX.use_rs & S_MEM.valid & S_MEM.regwrite & S_MEM.rd != 0 & S_MEM.rd == S_EX.rs;
  - else 01 if the same conditions hold against S_WB;
  - else 00.
  - EX/MEM wins when both stages match. S_EX.valid = 0 forces 00.
- Register 0 is never forwarded and never triggers LU.
- The register file is write-first. WB-to-ID same-cycle dependencies are not this block's concern.
- Latency:
  - Hold, bubble, flush and freeze outputs are combinational in the same cycle as their inputs.
  - The fwd selects reflect an instruction the cycle after it leaves ID.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with arbitrary inputs -> all outputs 0 and stall_cnt_o=0; stays clean the first cycle after release.
- EX-hazard: issue add rd=3, then sub rs=3 on consecutive cycles -> fwdA_o=10 while sub is in EX. With rd=3 in both EX/MEM and MEM/WB, 10 still wins. With rd=0 -> 00.
- MEM-hazard: add rd=5, an independent instruction, then or rt=5 -> fwdB_o=01 while or is in EX.
- Load-use: lw rd=7, then add rs=7 -> pc_hold_o=ifid_hold_o=idex_bubble_o=1 for exactly 1 cycle. stall_cnt_o goes 0->1, then fwdA_o=01 when add reaches EX.
- Priority: LU and branch_taken_i together -> ifid_flush_o=0. Assert mem_stall_i for 3 cycles during a pending forward -> pipe_freeze_o=1 for 3 cycles, fwd selects and stall_cnt_o unchanged, forwarding resumes correctly afterwards.
- Saturation and mid-op reset: with CNT_W=2, 5 load-use stalls -> stall_cnt_o=3. Assert rst_i during mem_stall_i=1 -> all state cleared next cycle.
